// File: rtl/digit_sub_pkg.sv
// Shared FSM encoding and parameter sanity check for digit_serial_subtractor.
package digit_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic bit widths_ok(input int n, input int d);
    return (n >= 1) && (d >= 1) && (d <= n) && ((n % d) == 0);
  endfunction

endpackage

// File: rtl/digit_sub_slice.sv
// Combinational D-bit ripple subtractor: d = x - y - bin, bout is the borrow out of bit D-1.
module digit_sub_slice #(
  parameter int D = 2
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         bin,
  output logic [D-1:0] d,
  output logic         bout
);

  logic [D:0] br;

  assign br[0] = bin;

  for (genvar gi = 0; gi < D; gi++) begin : g_cell
    assign d[gi]    = x[gi] ^ y[gi] ^ br[gi];
    // Borrow when y exceeds x, or they match and a borrow is already pending.
    assign br[gi+1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & br[gi]);
  end

  assign bout = br[D];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, D bits per clock, LSB digit first.
// Optional signed overflow output when DIGIT_SUB_OVERFLOW_EN is defined.
module digit_serial_subtractor
  import digit_sub_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow_out
`ifdef DIGIT_SUB_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int K  = (D > 0) ? N / D : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (!widths_ok(N, D)) begin : g_param_err
    $error("digit_serial_subtractor: need 1 <= D <= N and N %% D == 0 (N=%0d D=%0d)", N, D);
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic            brw_q, brw_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            bout_q, bout_d;
`ifdef DIGIT_SUB_OVERFLOW_EN
  logic            a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  logic [D-1:0]    dig;
  logic            dig_b;
  logic [N-1:0]    diff_shift;
  logic            accept;
  logic            last;

  digit_sub_slice #(.D(D)) u_slice (
    .x    (a_sh_q[D-1:0]),
    .y    (b_sh_q[D-1:0]),
    .bin  (brw_q),
    .d    (dig),
    .bout (dig_b)
  );

  // New digit enters at the top so the LSB digit ends up at bit 0 after K shifts.
  if (D == N) begin : g_single
    assign diff_shift = dig;
  end else begin : g_multi
    assign diff_shift = {dig, diff_q[N-1:D]};
  end

  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign last     = (cnt_q == CW'(K - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef DIGIT_SUB_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: ;
      RUN: begin
        a_sh_d = a_sh_q >> D;
        b_sh_d = b_sh_q >> D;
        brw_d  = dig_b;
        diff_d = diff_shift;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          bout_d  = dig_b;
`ifdef DIGIT_SUB_OVERFLOW_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_shift[N-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Accept overrides the DONE->IDLE exit so back-to-back ops skip the idle cycle.
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      a_sh_d  = a;
      b_sh_d  = b;
      brw_d   = borrow_in;
`ifdef DIGIT_SUB_OVERFLOW_EN
      a_msb_d = a[N-1];
      b_msb_d = b[N-1];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef DIGIT_SUB_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef DIGIT_SUB_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef DIGIT_SUB_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Scoreboard bench for digit_serial_subtractor at D=2 (directed + random), D=1 and D=8 (random).
// Checks overflow as well when DIGIT_SUB_OVERFLOW_EN is defined.
`timescale 1ns/1ps
module tb_digit_serial_subtractor;

  localparam int N  = 8;
  localparam int NI = 3;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    int           idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [N-1:0] a_s       [NI];
  logic [N-1:0] b_s       [NI];
  logic         bin_s     [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [N-1:0] diff_s    [NI];
  logic         bout_s    [NI];
`ifdef DIGIT_SUB_OVERFLOW_EN
  logic         ovf_s     [NI];
`endif

  int n_cmp    = 0;
  int n_bad    = 0;
  int edge_cnt = 0;
  int pending  [NI];
  bit rnd_rdy  [NI];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic bv_in, input int idx);
    exp_t e;
    logic [N:0] full;
    full   = {1'b0, av} - {1'b0, bv} - {{N{1'b0}}, bv_in};
    e.a    = av;
    e.b    = bv;
    e.bin  = bv_in;
    e.diff = full[N-1:0];
    e.bout = full[N];
    e.ovf  = (av[N-1] ^ bv[N-1]) & (av[N-1] ^ e.diff[N-1]);
    e.idx  = idx;
    return e;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int DG = (gi == 0) ? 2 : ((gi == 1) ? 1 : 8);
    localparam int KG = N / DG;

    exp_t sb_q[$];
    exp_t e;
    bit   hold;

    digit_serial_subtractor #(.N(N), .D(DG)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[gi]),
      .in_ready   (in_ready[gi]),
      .a          (a_s[gi]),
      .b          (b_s[gi]),
      .borrow_in  (bin_s[gi]),
      .out_valid  (out_valid[gi]),
      .out_ready  (out_ready[gi]),
      .diff       (diff_s[gi]),
      .borrow_out (bout_s[gi])
`ifdef DIGIT_SUB_OVERFLOW_EN
      ,
      .overflow   (ovf_s[gi])
`endif
    );

    // Sampled at negedge: these are the values the next rising edge will act on.
    initial begin
      hold = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          sb_q.delete();
          pending[gi] = 0;
          hold = 1'b0;
        end else begin
          if (out_valid[gi]) begin
            if (sb_q.size() == 0) begin
              check_val($sformatf("D%0d_spurious_valid", DG), 32'(out_valid[gi]), 32'd0);
            end else begin
              e = sb_q[0];
              if (!hold)
                check_val($sformatf("D%0d_latency", DG), 32'(edge_cnt - e.idx), 32'(KG));
              check_val($sformatf("D%0d_diff", DG), 32'(diff_s[gi]), 32'(e.diff));
              check_val($sformatf("D%0d_borrow_out", DG), 32'(bout_s[gi]), 32'(e.bout));
              check_val($sformatf("D%0d_in_ready_done", DG), 32'(in_ready[gi]), 32'(out_ready[gi]));
`ifdef DIGIT_SUB_OVERFLOW_EN
              check_val($sformatf("D%0d_overflow", DG), 32'(ovf_s[gi]), 32'(e.ovf));
`endif
              if (out_ready[gi]) begin
                if (gi == 0 || !rnd_rdy[gi])
                  $display("[D=%0d] %02h - %02h - %0d -> diff=%02h borrow=%0d ovf=%0d",
                           DG, e.a, e.b, e.bin, e.diff, e.bout, e.ovf);
                void'(sb_q.pop_front());
                pending[gi]--;
              end
            end
            hold = !out_ready[gi];
          end else begin
            hold = 1'b0;
          end
          if (in_valid[gi] && in_ready[gi]) begin
            sb_q.push_back(model(a_s[gi], b_s[gi], bin_s[gi], edge_cnt + 1));
            pending[gi]++;
          end
        end
      end
    end
  end

  task automatic step(input int idx);
    @(posedge clk);
    #1;
    if (rnd_rdy[idx]) out_ready[idx] = ($urandom_range(3) != 0);
    #1;
  endtask

  task automatic send(input int idx, input logic [N-1:0] av, input logic [N-1:0] bv,
                      input logic bv_in);
    bit acc;
    acc = 1'b0;
    in_valid[idx] = 1'b1;
    a_s[idx]      = av;
    b_s[idx]      = bv;
    bin_s[idx]    = bv_in;
    #1;
    for (int t = 0; t < 100 && !acc; t++) begin
      acc = in_ready[idx];
      step(idx);
    end
    if (!acc) check_val("accept_timeout", 32'(acc), 32'd1);
    in_valid[idx] = 1'b0;
  endtask

  task automatic drain(input int idx);
    int t;
    t = 0;
    while (pending[idx] != 0 && t < 400) begin
      step(idx);
      t++;
    end
    check_val("drain_pending", 32'(pending[idx]), 32'd0);
  endtask

  task automatic rand_run(input int idx, input int n);
    rnd_rdy[idx] = 1'b1;
    repeat (n) send(idx, N'($urandom), N'($urandom), 1'($urandom_range(1)));
    rnd_rdy[idx]   = 1'b0;
    out_ready[idx] = 1'b1;
    drain(idx);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      a_s[i]       = '0;
      b_s[i]       = '0;
      bin_s[i]     = 1'b0;
      out_ready[i] = 1'b0;
      rnd_rdy[i]   = 1'b0;
      pending[i]   = 0;
    end
    rst = 1'b1;
    step(0);
    step(0);
    for (int i = 0; i < NI; i++) begin
      check_val("rst_out_valid", 32'(out_valid[i]), 32'd0);
      check_val("rst_in_ready", 32'(in_ready[i]), 32'd0);
      check_val("rst_diff", 32'(diff_s[i]), 32'd0);
      check_val("rst_borrow_out", 32'(bout_s[i]), 32'd0);
    end
    rst = 1'b0;
    #1;
    check_val("idle_in_ready", 32'(in_ready[0]), 32'd1);

    // Basic ops, back-to-back pairs, overflow corners
    out_ready[0] = 1'b1;
    send(0, 8'h5A, 8'h3C, 1'b0);
    drain(0);
    send(0, 8'h00, 8'h01, 1'b0);
    send(0, 8'hFF, 8'hFF, 1'b1);
    drain(0);
    send(0, 8'h80, 8'h01, 1'b0);
    send(0, 8'h05, 8'h03, 1'b0);
    drain(0);

    // Backpressure: hold result 5 cycles, then release together with a new op
    out_ready[0] = 1'b0;
    send(0, 8'h33, 8'h44, 1'b1);
    for (int t = 0; t < 20 && !out_valid[0]; t++) step(0);
    check_val("bp_out_valid", 32'(out_valid[0]), 32'd1);
    repeat (5) step(0);
    check_val("bp_in_ready_held", 32'(in_ready[0]), 32'd0);
    out_ready[0] = 1'b1;
    send(0, 8'hC8, 8'h19, 1'b0);
    drain(0);

    // Reset during the second RUN cycle aborts the op
    send(0, 8'h12, 8'h34, 1'b0);
    step(0);
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    check_val("midrst_diff", 32'(diff_s[0]), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready[0]), 32'd0);
    step(0);
    rst = 1'b0;
    #1;
    check_val("postrst_in_ready", 32'(in_ready[0]), 32'd1);
    check_val("postrst_out_valid", 32'(out_valid[0]), 32'd0);
    send(0, 8'hA7, 8'h5E, 1'b1);
    drain(0);

    rand_run(0, 200);
    fork
      rand_run(1, 1000);
      rand_run(2, 1000);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
